// File: rtl/qam16_pkg.sv
// qam16_pkg: shared constants, types and helper functions for the 16-QAM
// symbol source.
//   - Level codes L_M3/L_M1/L_P1/L_P3 (3-bit two's complement)
//   - PRBS-15 width and feedback tap positions
//   - Output-slot state type and symbol payload struct
//   - gray_map / map_symbol: Gray mapping from bit pairs to levels
package qam16_pkg;

  localparam int unsigned SYM_W        = 3;
  localparam int unsigned BITS_PER_SYM = 4;

  localparam int unsigned PRBS_W      = 15;
  localparam int unsigned PRBS_TAP_HI = 14;
  localparam int unsigned PRBS_TAP_LO = 13;

  localparam logic [SYM_W-1:0] L_M3 = 3'b101;
  localparam logic [SYM_W-1:0] L_M1 = 3'b111;
  localparam logic [SYM_W-1:0] L_P1 = 3'b001;
  localparam logic [SYM_W-1:0] L_P3 = 3'b011;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [SYM_W-1:0] i;
    logic [SYM_W-1:0] q;
  } sym_t;

  // Gray code: adjacent levels differ in one bit.
  function automatic logic [SYM_W-1:0] gray_map(input logic [1:0] bits);
    logic [SYM_W-1:0] lvl;
    case (bits)
      2'b00:   lvl = L_M3;
      2'b01:   lvl = L_M1;
      2'b11:   lvl = L_P1;
      default: lvl = L_P3;
    endcase
    return lvl;
  endfunction

  // Upper bit pair drives I, lower pair drives Q.
  function automatic sym_t map_symbol(input logic [BITS_PER_SYM-1:0] bits);
    sym_t s;
    s.i = gray_map(bits[3:2]);
    s.q = gray_map(bits[1:0]);
    return s;
  endfunction

endpackage

// File: rtl/prbs15_gen.sv
// prbs15_gen: Fibonacci PRBS-15 generator, x^15 + x^14 + 1.
// The register MSB is the output bit; on each step the register shifts
// toward the MSB and bit14 XOR bit13 enters at the LSB.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  asynchronous active-low reset, loads seed
//   step    in  advance the sequence by one bit this cycle
//   seed    in  reset value (must be nonzero)
//   bit_out out current output bit (register MSB)
module prbs15_gen
  import qam16_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              step,
  input  logic [PRBS_W-1:0] seed,
  output logic              bit_out
);

  logic [PRBS_W-1:0] r_lfsr;
  logic              w_feedback;

  assign w_feedback = r_lfsr[PRBS_TAP_HI] ^ r_lfsr[PRBS_TAP_LO];

  // Shift register; seed is expected to be a tie-off constant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr <= seed;
    end else if (step) begin
      r_lfsr <= {r_lfsr[PRBS_W-2:0], w_feedback};
    end
  end

  assign bit_out = r_lfsr[PRBS_W-1];

endmodule

// File: rtl/qam16_symbol_source.sv
// qam16_symbol_source: 16-QAM test symbol source for a pulse-shaping filter.
// Every SYM_DIV clocks (while enable is high) four source bits are collected
// on divider counts 0..3, Gray-mapped to an I/Q level pair and offered on a
// one-entry valid/ready output slot. A symbol arriving while the slot is
// still occupied and not being accepted is discarded and sym_drop latches.
//
// Build option: define QAM16_TEST_PATTERN_EN to replace the PRBS-15 source
// with a 4-bit counter that advances once per symbol tick.
//
// Parameters:
//   SYM_DIV    clocks per symbol, 4..256
//   PRBS_SEED  PRBS-15 reset state, nonzero
// Ports:
//   clock_5000 in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   enable     in   symbol generation runs while high
//   sym_ready  in   downstream accepts the symbol this cycle
//   sym_valid  out  i_sym/q_sym hold a valid symbol
//   i_sym      out  in-phase level, 3-bit two's complement
//   q_sym      out  quadrature level, 3-bit two's complement
//   sym_drop   out  sticky: a symbol was discarded (slot full)
module qam16_symbol_source
  import qam16_pkg::*;
#(
  parameter int unsigned       SYM_DIV   = 8,
  parameter logic [PRBS_W-1:0] PRBS_SEED = 15'h7FFF
) (
  input  logic             clock_5000,
  input  logic             reset,
  input  logic             enable,
  input  logic             sym_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] i_sym,
  output logic [SYM_W-1:0] q_sym,
  output logic             sym_drop
);

  localparam int unsigned      DIV_W    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);

  logic [DIV_W-1:0]        r_div_cnt;
  logic                    w_tick;
  logic [BITS_PER_SYM-1:0] w_sym_bits;

  assign w_tick = enable && (r_div_cnt == DIV_LAST);

  // Symbol divider; held at zero while disabled so assembly restarts cleanly.
  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

`ifdef QAM16_TEST_PATTERN_EN

  logic [BITS_PER_SYM-1:0] r_tp_cnt;

  // Test pattern: counter value is the symbol, advanced once per tick.
  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      r_tp_cnt <= '0;
    end else if (w_tick) begin
      r_tp_cnt <= r_tp_cnt + BITS_PER_SYM'(1);
    end
  end

  assign w_sym_bits = r_tp_cnt;

`else

  localparam logic [DIV_W-1:0] SHIFT_LAST = DIV_W'(BITS_PER_SYM - 1);

  logic                    w_shift;
  logic                    w_prbs_bit;
  logic [BITS_PER_SYM-1:0] r_bits;
  logic [BITS_PER_SYM-1:0] w_bits_nxt;

  assign w_shift = enable && (r_div_cnt <= SHIFT_LAST);

  prbs15_gen u_prbs (
    .clock   (clock_5000),
    .reset   (reset),
    .step    (w_shift),
    .seed    (PRBS_SEED),
    .bit_out (w_prbs_bit)
  );

  assign w_bits_nxt = w_shift ? {r_bits[BITS_PER_SYM-2:0], w_prbs_bit} : r_bits;

  // Bit assembly, MSB first; partial bits are thrown away when disabled.
  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      r_bits <= '0;
    end else if (!enable) begin
      r_bits <= '0;
    end else begin
      r_bits <= w_bits_nxt;
    end
  end

  // Use the next value so the last bit counts when the tick shares its cycle.
  assign w_sym_bits = w_bits_nxt;

`endif

  slot_state_e r_slot_state;
  slot_state_e w_slot_state_nxt;
  sym_t        r_sym;
  sym_t        w_sym_nxt;
  logic        r_drop;
  logic        w_drop_nxt;

  // Output slot register.
  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      r_slot_state <= SLOT_EMPTY;
      r_sym        <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_slot_state <= w_slot_state_nxt;
      r_sym        <= w_sym_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  // Output slot next state: load on tick if free or being drained, else drop.
  always_comb begin
    w_slot_state_nxt = r_slot_state;
    w_sym_nxt        = r_sym;
    w_drop_nxt       = r_drop;
    case (r_slot_state)
      SLOT_EMPTY: begin
        if (w_tick) begin
          w_slot_state_nxt = SLOT_FULL;
          w_sym_nxt        = map_symbol(w_sym_bits);
        end
      end
      SLOT_FULL: begin
        if (w_tick) begin
          if (sym_ready) begin
            w_sym_nxt = map_symbol(w_sym_bits);
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else if (sym_ready) begin
          w_slot_state_nxt = SLOT_EMPTY;
        end
      end
      default: begin
        w_slot_state_nxt = SLOT_EMPTY;
      end
    endcase
  end

  assign sym_valid = (r_slot_state == SLOT_FULL);
  assign i_sym     = r_sym.i;
  assign q_sym     = r_sym.q;
  assign sym_drop  = r_drop;

endmodule

// File: doc/qam16_symbol_source.md
QAM16_SYMBOL_SOURCE -- requirements
Module: qam16_symbol_source

Interface
REQ-001 Parameter SYM_DIV, default 8: clocks per symbol; legal range 4..256.
REQ-002 Parameter PRBS_SEED, default 15'h7FFF: PRBS-15 reset state; must be nonzero.
REQ-003 clock_5000  input  1: single clock, rising-edge; all state is in this domain.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 enable  input  1: symbol generation runs while high.
REQ-006 sym_ready  input  1: downstream pulse-shaping filter accepts the symbol this cycle.
REQ-007 sym_valid  output  1: i_sym/q_sym hold a valid symbol.
REQ-008 i_sym  output  3: in-phase level, two's complement, one of {-3,-1,+1,+3}.
REQ-009 q_sym  output  3: quadrature level, same encoding as i_sym.
REQ-010 sym_drop  output  1: sticky flag; a symbol was discarded because the output slot was full.

Function
REQ-011 Bit source SHALL be PRBS-15, polynomial x^15+x^14+1, Fibonacci form; the output bit is the register MSB and the feedback is bit14 XOR bit13.
REQ-012 Divider counter div_cnt SHALL count 0..SYM_DIV-1 and wrap while enable=1; it SHALL be held at 0 while enable=0.
REQ-013 PRBS SHALL advance exactly once per cycle when enable=1 and div_cnt is 0..3; the 4 bits SHALL be shifted MSB-first into a 4-bit register b3..b0.
REQ-014 At div_cnt=SYM_DIV-1 a symbol tick occurs; the mapped symbol SHALL appear on the outputs the following cycle (sym_valid=1), which is a latency of SYM_DIV clocks from the first bit.
REQ-015 Gray mapping SHALL be applied: b3b2 gives I and b1b0 gives Q, with 00->-3 (3'b101), 01->-1 (3'b111), 11->+1 (3'b001), 10->+3 (3'b011).
REQ-016 Handshake: a symbol SHALL transfer on a cycle with sym_valid=1 and sym_ready=1.
REQ-017 sym_valid SHALL clear after a transfer unless a new symbol loads in the same cycle.
REQ-018 Outputs SHALL be stable while sym_valid=1 and sym_ready=0.
REQ-019 A tick SHALL load the output slot if sym_valid=0, or if sym_valid=1 and sym_ready=1 in the same cycle; otherwise the new symbol is discarded and sym_drop is set.
REQ-020 sym_drop SHALL clear only on reset.
REQ-021 Deasserting enable SHALL discard the partially assembled bits and hold the PRBS state; a pending valid symbol SHALL remain until it is accepted.
REQ-022 Reasserting enable SHALL restart assembly at div_cnt=0 and continue the PRBS sequence.

Reset
REQ-023 While reset=0: sym_valid=0, i_sym=0, q_sym=0, sym_drop=0, div_cnt=0, the bit register is 0 and the PRBS register is PRBS_SEED.
REQ-024 Reset mid-symbol SHALL abandon the symbol immediately, with no output activity.
REQ-025 Release of reset SHALL be safe with enable already high; the first PRBS step occurs on the first rising edge after release.

Configuration
REQ-026 Macro QAM16_TEST_PATTERN_EN SHALL control the bit source.
REQ-027 With QAM16_TEST_PATTERN_EN defined, the PRBS SHALL be replaced by a 4-bit counter starting at 0 and incrementing once per tick (wrap 15->0); its value is used directly as b3..b0.
REQ-028 Without QAM16_TEST_PATTERN_EN, the PRBS path is used and no counter logic exists.

Structure
REQ-029 Shared package qam16_pkg SHALL hold the level constants (L_M3, L_M1, L_P1, L_P3), the PRBS width/taps constants and the Gray-map function.
REQ-030 Sub-module prbs15_gen (clock, reset, step, seed, bit_out) SHALL implement the PRBS; qam16_symbol_source instantiates it once.

Verification
REQ-031 Default params, PRBS, sym_ready=1, enable raised after reset -> first symbol bits 1111 -> i_sym=3'b001, q_sym=3'b001, sym_valid high for exactly 1 cycle, 8 clocks after enable.
REQ-032 Test-pattern build, sym_ready=1 -> 16 successive symbols; symbol 0 is I=3'b101, Q=3'b101; symbol 10 (1010) is I=3'b011, Q=3'b011; the pattern wraps to symbol 0 at the 17th symbol.
REQ-033 sym_ready=0 held for 2*SYM_DIV clocks -> first symbol stays stable, the second tick sets sym_drop=1, and the outputs are unchanged.
REQ-034 Tick cycle coincides with sym_valid=1 and sym_ready=1 -> the new symbol loads, sym_valid stays 1 and sym_drop stays 0.
REQ-035 Enable dropped at div_cnt=2, then restored -> no symbol from the partial bits; the next symbol uses PRBS bits 3..6 of the continued sequence.
REQ-036 reset asserted at div_cnt=5 with sym_valid=1 -> all outputs 0 asynchronously; after release the sequence restarts from PRBS_SEED.
